eth_mac_lb_mf: RTL and testbench
================================

Name: eth_mac_lb_mf

Overview:
Multi-frame store-and-forward Ethernet loopback, the parametrised successor of the single-frame eth_mac buffer. TX bytes are written into a circular byte FIFO, and complete frames are committed through a length-descriptor queue. RX streams committed frames out concurrently with TX intake, so frames overlap. Runt, oversize and errored frames are filtered, and drop and throughput statistics are exported for the UVM scoreboard.

Parameters:
FIFO_BYTES, 2048, byte buffer depth; power of 2; must be >= MAX_FRAME.
MAX_FRAME, 1518, largest legal frame length in bytes.
MIN_FRAME, 64, smallest legal frame length in bytes.
DESC_DEPTH, 8, number of committed frames that can be queued; power of 2.
CNT_W, 16, width of the statistics counters.

Ports:
ETH_CLK  in  1  single clock; all logic on posedge.
ETH_RST  in  1  asynchronous, active-high reset.
tx_valid  in  1  TX byte valid.
tx_ready  out  1  TX byte accept; combinational from state.
tx_data  in  8  TX byte.
tx_last  in  1  last byte of the frame.
tx_err  in  1  marks the frame errored; sampled on every accepted byte.
rx_valid  out  1  RX byte valid; registered.
rx_ready  in  1  downstream accept.
rx_data  out  8  RX byte; registered.
rx_last  out  1  last byte of the RX frame; registered.
frames_pending  out  $clog2(DESC_DEPTH)+1  committed frames not yet fully read.
stat_rx_frames  out  CNT_W  frames fully emitted on RX; saturating.
stat_drop_frames  out  CNT_W  frames dropped; saturating.
drop_pulse  out  1  one-cycle pulse per dropped frame.
drop_cause  out  2  valid with drop_pulse: 01 runt, 10 too long, 11 tx_err.

Behaviour:
- Reset, asynchronous and immediate: all pointers, counters and the descriptor queue go to 0; all outputs go to 0, including tx_ready. Partial and queued frames are lost. FIFO contents are don't-care.
- Handshake rules:
  - A byte transfers on a posedge where valid && ready.
  - rx_data and rx_last stay stable while rx_valid && !rx_ready.
  - rx_valid never deasserts without a transfer.
- Write side: pointers wp (speculative) and fs (start of the current frame). Frame length L counts accepted bytes, including the last byte.
- TX FSM, ACCEPT state:
  - tx_ready = (used bytes < FIFO_BYTES) && (desc_count < DESC_DEPTH).
  - Used bytes = wp - rp, modulo 2*FIFO_BYTES, using an extra wrap bit.
- TX FSM, DISCARD state:
  - Entered when a byte is accepted with L already equal to MAX_FRAME.
  - tx_ready = 1; bytes are not written.
  - On an accepted tx_last: rollback, then back to ACCEPT.
- Commit on an accepted tx_last in ACCEPT:
  - Cause priority is err > too long > runt. err means tx_err was seen on any byte of the frame. Runt means L < MIN_FRAME.
  - If any cause is present: rollback (wp <= fs, L <= 0), drop_pulse = 1 on the following cycle with drop_cause set, stat_drop_frames += 1.
  - Otherwise: push descriptor L, fs <= wp+1, L <= 0.
- Frame visibility: a frame is visible to RX on the edge after its commit. The first rx_valid rises exactly 2 edges after the edge that accepted tx_last, provided RX is idle.
- RX FSM:
  - IDLE to STREAM when desc_count > 0.
  - In STREAM, the output register loads fifo[rp] when (!rx_valid || rx_ready) and bytes remain in the frame.
  - On the transfer of the last byte: rx_last, pop the descriptor, stat_rx_frames += 1.
  - After the last byte: if another descriptor is present, stay in STREAM with no bubble; otherwise go to IDLE.
- Simultaneous descriptor push and pop: count unchanged. Simultaneous write and read on the same cycle are legal at any fullness.
- Pointer wrap-around at FIFO_BYTES is transparent to frames that span the wrap.
- Statistics saturate at 2^CNT_W - 1.

Optional Feature:
Macro: ETH_LB_PAD_EN.
- Defined: a runt frame without an error is not dropped.
  - After the tx_last accept, the TX FSM enters PAD with tx_ready = 0.
  - PAD writes 0x00 one byte per cycle, stalling while the FIFO is full, until L == MIN_FRAME; it then commits and returns to ACCEPT.
  - Cause 01 is never reported.
- Undefined: runts are dropped with cause 01, and the PAD state does not exist.

Test Plan:
1. Reset, then one 64-byte frame 0x00..0x3F with rx_ready = 1 -> RX bytes are identical; rx_last on byte 64; first rx_valid 2 edges after the tx_last accept; stat_rx_frames = 1.
2. Frames of 64, 100 and 1518 bytes sent with rx_ready = 0, then rx_ready = 1 -> frames_pending reaches 3; output is in order with no gap between frames; stat_rx_frames = 3; frames_pending returns to 0.
3. A 1519-byte frame followed by a 64-byte frame -> drop_pulse with cause 10; tx_ready = 1 throughout the discard; only the 64-byte frame is emitted; stat_drop_frames = 1.
4. A 10-byte frame -> without the macro: cause 01 and nothing on RX. With ETH_LB_PAD_EN: a 64-byte frame whose bytes 10..63 are 0x00.
5. tx_err on byte 5 of an 80-byte frame, then a 200-byte frame with rx_ready randomly toggled and spanning the FIFO wrap -> cause 11 for the first frame; second frame intact, with rx_data held while stalled.
6. ETH_RST asserted mid-RX stream with 2 frames queued -> rx_valid, tx_ready, frames_pending and stats are 0 immediately. After release, a new 64-byte frame passes cleanly.

Source files
------------

// File: rtl/eth_mac_lb_mf.sv
// Multi-frame store-and-forward Ethernet loopback: circular byte FIFO plus length-descriptor queue.
// Optional ETH_LB_PAD_EN: zero-pad error-free runts up to MIN_FRAME instead of dropping them.
module eth_mac_lb_mf #(
  parameter int FIFO_BYTES = 2048,
  parameter int MAX_FRAME  = 1518,
  parameter int MIN_FRAME  = 64,
  parameter int DESC_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                        ETH_CLK,
  input  logic                        ETH_RST,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_last,
  input  logic                        tx_err,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [7:0]                  rx_data,
  output logic                        rx_last,
  output logic [$clog2(DESC_DEPTH):0] frames_pending,
  output logic [CNT_W-1:0]            stat_rx_frames,
  output logic [CNT_W-1:0]            stat_drop_frames,
  output logic                        drop_pulse,
  output logic [1:0]                  drop_cause
);
  localparam int AW = $clog2(FIFO_BYTES);
  localparam int LW = $clog2(MAX_FRAME + 1);
  localparam int DW = $clog2(DESC_DEPTH);

  typedef enum logic [1:0] {
    TX_ACCEPT,
    TX_DISCARD
`ifdef ETH_LB_PAD_EN
    , TX_PAD
`endif
  } tx_st_e;
  typedef enum logic {RX_IDLE, RX_STREAM} rx_st_e;

  tx_st_e          tx_st_q, tx_st_d;
  rx_st_e          rx_st_q;
  logic [AW:0]     wp_q, wp_d, fs_q, fs_d, rp_q, used;
  logic [LW-1:0]   len_q, len_d, len_inc, push_len, rem_q, ld_len;
  logic            err_q, err_d, err_any, en_q;
  logic            full, desc_room, tx_fire, we, push, pop, ld, drop, rx_xfer;
  logic [7:0]      wd;
  logic [1:0]      cause;
  logic [7:0]      mem [FIFO_BYTES];
  logic [LW-1:0]   desc_mem [DESC_DEPTH];
  logic [DW-1:0]   dwp_q, drp_q, drp_nxt;
  logic [DW:0]     dcnt_q;
  logic            rx_valid_q, rx_last_q, drop_pulse_q;
  logic [7:0]      rx_data_q;
  logic [1:0]      drop_cause_q;
  logic [CNT_W-1:0] stat_rx_q, stat_drop_q;

  // used counts speculative bytes too, so an in-flight frame can never overwrite unread data
  assign used      = wp_q - rp_q;
  assign full      = (used == (AW+1)'(FIFO_BYTES));
  assign desc_room = (dcnt_q != (DW+1)'(DESC_DEPTH));
  assign tx_fire   = tx_valid && tx_ready;
  assign len_inc   = len_q + LW'(1);
  assign err_any   = err_q | tx_err;
  assign rx_xfer   = rx_valid_q && rx_ready;
  assign pop       = rx_xfer && rx_last_q;
  assign drp_nxt   = drp_q + DW'(1);

  always_comb begin
    tx_ready = 1'b0;
    if (en_q) begin
      case (tx_st_q)
        TX_ACCEPT:  tx_ready = !full && desc_room;
        TX_DISCARD: tx_ready = 1'b1;
        default:    tx_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    wp_d     = wp_q;
    fs_d     = fs_q;
    len_d    = len_q;
    err_d    = err_q;
    we       = 1'b0;
    wd       = tx_data;
    push     = 1'b0;
    push_len = len_inc;
    drop     = 1'b0;
    cause    = 2'b00;
    case (tx_st_q)
      TX_ACCEPT: if (tx_fire) begin
        if (len_q == LW'(MAX_FRAME)) begin
          err_d = err_any;
          if (tx_last) begin
            drop  = 1'b1;
            cause = err_any ? 2'b11 : 2'b10;
            wp_d  = fs_q;
            len_d = '0;
            err_d = 1'b0;
          end else begin
            tx_st_d = TX_DISCARD;
          end
        end else begin
          we    = 1'b1;
          wp_d  = wp_q + (AW+1)'(1);
          len_d = len_inc;
          err_d = err_any;
          if (tx_last) begin
            if (err_any || len_inc < LW'(MIN_FRAME)) begin
`ifdef ETH_LB_PAD_EN
              if (!err_any) begin
                tx_st_d = TX_PAD;
              end else
`endif
              begin
                drop  = 1'b1;
                cause = err_any ? 2'b11 : 2'b01;
                wp_d  = fs_q;
                len_d = '0;
                err_d = 1'b0;
              end
            end else begin
              push  = 1'b1;
              fs_d  = wp_q + (AW+1)'(1);
              len_d = '0;
              err_d = 1'b0;
            end
          end
        end
      end
      TX_DISCARD: if (tx_fire) begin
        err_d = err_any;
        if (tx_last) begin
          drop    = 1'b1;
          cause   = err_any ? 2'b11 : 2'b10;
          wp_d    = fs_q;
          len_d   = '0;
          err_d   = 1'b0;
          tx_st_d = TX_ACCEPT;
        end
      end
`ifdef ETH_LB_PAD_EN
      TX_PAD: if (!full && desc_room) begin
        we    = 1'b1;
        wd    = 8'h00;
        wp_d  = wp_q + (AW+1)'(1);
        len_d = len_inc;
        if (len_inc == LW'(MIN_FRAME)) begin
          push     = 1'b1;
          push_len = LW'(MIN_FRAME);
          fs_d     = wp_q + (AW+1)'(1);
          len_d    = '0;
          err_d    = 1'b0;
          tx_st_d  = TX_ACCEPT;
        end
      end
`endif
      default: tx_st_d = TX_ACCEPT;
    endcase
  end

  always_ff @(posedge ETH_CLK or posedge ETH_RST) begin
    if (ETH_RST) begin
      tx_st_q      <= TX_ACCEPT;
      wp_q         <= '0;
      fs_q         <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
      en_q         <= 1'b0;
      drop_pulse_q <= 1'b0;
      drop_cause_q <= 2'b00;
      stat_drop_q  <= '0;
    end else begin
      tx_st_q      <= tx_st_d;
      wp_q         <= wp_d;
      fs_q         <= fs_d;
      len_q        <= len_d;
      err_q        <= err_d;
      en_q         <= 1'b1;
      drop_pulse_q <= drop;
      drop_cause_q <= drop ? cause : 2'b00;
      if (drop && stat_drop_q != '1) stat_drop_q <= stat_drop_q + CNT_W'(1);
    end
  end

  always_ff @(posedge ETH_CLK) begin
    if (we)   mem[wp_q[AW-1:0]] <= wd;
    if (push) desc_mem[dwp_q]   <= push_len;
  end

  always_ff @(posedge ETH_CLK or posedge ETH_RST) begin
    if (ETH_RST) begin
      dwp_q  <= '0;
      drp_q  <= '0;
      dcnt_q <= '0;
    end else begin
      if (push) dwp_q <= dwp_q + DW'(1);
      if (pop)  drp_q <= drp_nxt;
      if (push && !pop)      dcnt_q <= dcnt_q + (DW+1)'(1);
      else if (pop && !push) dcnt_q <= dcnt_q - (DW+1)'(1);
    end
  end

  // Look ahead to the next descriptor so back-to-back frames stream without a bubble
  always_comb begin
    ld     = 1'b0;
    ld_len = rem_q;
    if (rx_st_q == RX_STREAM) begin
      if (rem_q != '0) begin
        ld = !rx_valid_q || rx_ready;
      end else if (pop && dcnt_q > (DW+1)'(1)) begin
        ld     = 1'b1;
        ld_len = desc_mem[drp_nxt];
      end
    end
  end

  always_ff @(posedge ETH_CLK or posedge ETH_RST) begin
    if (ETH_RST) begin
      rx_st_q    <= RX_IDLE;
      rp_q       <= '0;
      rem_q      <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_last_q  <= 1'b0;
      stat_rx_q  <= '0;
    end else begin
      if (pop && stat_rx_q != '1) stat_rx_q <= stat_rx_q + CNT_W'(1);
      case (rx_st_q)
        RX_IDLE: if (dcnt_q != '0) begin
          rx_st_q <= RX_STREAM;
          rem_q   <= desc_mem[drp_q];
        end
        RX_STREAM: begin
          if (ld) begin
            rx_valid_q <= 1'b1;
            rx_data_q  <= mem[rp_q[AW-1:0]];
            rx_last_q  <= (ld_len == LW'(1));
            rp_q       <= rp_q + (AW+1)'(1);
            rem_q      <= ld_len - LW'(1);
          end else if (rx_xfer) begin
            rx_valid_q <= 1'b0;
            rx_last_q  <= 1'b0;
            if (rx_last_q) rx_st_q <= RX_IDLE;
          end
        end
        default: rx_st_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_valid         = rx_valid_q;
  assign rx_data          = rx_data_q;
  assign rx_last          = rx_last_q;
  assign frames_pending   = dcnt_q;
  assign stat_rx_frames   = stat_rx_q;
  assign stat_drop_frames = stat_drop_q;
  assign drop_pulse       = drop_pulse_q;
  assign drop_cause       = drop_cause_q;
endmodule

// File: tb/tb_eth_mac_lb_mf.sv
// Bench for eth_mac_lb_mf: directed frame sequence, queue-based frame-level reference model.
module tb_eth_mac_lb_mf;
  localparam int FIFO_BYTES = 2048;
  localparam int MAX_FRAME  = 1518;
  localparam int MIN_FRAME  = 64;
  localparam int DESC_DEPTH = 8;
  localparam int CNT_W      = 16;

  logic        ETH_CLK = 1'b0;
  logic        ETH_RST = 1'b1;
  logic        tx_valid = 1'b0, tx_last = 1'b0, tx_err = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready;
  logic        rx_valid, rx_last;
  logic        rx_ready = 1'b1;
  logic [7:0]  rx_data;
  logic [3:0]  frames_pending;
  logic [15:0] stat_rx_frames, stat_drop_frames;
  logic        drop_pulse;
  logic [1:0]  drop_cause;

  eth_mac_lb_mf #(
    .FIFO_BYTES(FIFO_BYTES), .MAX_FRAME(MAX_FRAME), .MIN_FRAME(MIN_FRAME),
    .DESC_DEPTH(DESC_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .ETH_CLK(ETH_CLK), .ETH_RST(ETH_RST),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_last(tx_last), .tx_err(tx_err),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_last(rx_last),
    .frames_pending(frames_pending), .stat_rx_frames(stat_rx_frames),
    .stat_drop_frames(stat_drop_frames), .drop_pulse(drop_pulse), .drop_cause(drop_cause)
  );

  always #5 ETH_CLK = ~ETH_CLK;

  int total = 0, bad = 0;
  int cyc = 0, rise_cyc = -1, t_last = 0, rx_cnt = 0;
  int n_rx = 0, n_drop = 0;
  logic [8:0] exp_q [$];
  logic [1:0] exp_drop [$];

  always @(posedge ETH_CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: transfers, hold-while-stalled and drop reports, sampled on the falling edge
  bit         hold_on = 1'b0, prev_v = 1'b0;
  logic [8:0] hold_v;
  always @(negedge ETH_CLK) begin
    logic [9:0] e;
    logic [1:0] ec;
    if (ETH_RST) begin
      hold_on = 1'b0;
      prev_v  = 1'b0;
    end else begin
      if (hold_on) chk("rx_hold", {rx_valid, rx_last, rx_data}, {1'b1, hold_v});
      if (rx_valid && !prev_v) rise_cyc = cyc;
      prev_v = rx_valid;
      if (rx_valid && rx_ready) begin
        e = 10'h000;
        if (exp_q.size() != 0) e = {1'b1, exp_q.pop_front()};
        chk("rx_byte", {1'b1, rx_last, rx_data}, e);
        rx_cnt++;
      end
      hold_on = rx_valid && !rx_ready;
      hold_v  = {rx_last, rx_data};
      if (drop_pulse) begin
        ec = 2'b00;
        if (exp_drop.size() != 0) ec = exp_drop.pop_front();
        chk("drop_cause", drop_cause, ec);
      end
    end
  end

  task automatic send(input int len, input int err_at, input bit seq);
    logic [7:0] d [$];
    int w;
    for (int i = 0; i < len; i++) d.push_back(seq ? 8'(i) : 8'($urandom));
    if (err_at >= 0 && err_at < len) begin
      exp_drop.push_back(2'b11); n_drop++;
    end else if (len > MAX_FRAME) begin
      exp_drop.push_back(2'b10); n_drop++;
    end else if (len < MIN_FRAME) begin
`ifdef ETH_LB_PAD_EN
      for (int i = 0; i < MIN_FRAME; i++)
        exp_q.push_back({i == MIN_FRAME - 1, (i < len) ? d[i] : 8'h00});
      n_rx++;
`else
      exp_drop.push_back(2'b01); n_drop++;
`endif
    end else begin
      for (int i = 0; i < len; i++) exp_q.push_back({i == len - 1, d[i]});
      n_rx++;
    end
    for (int i = 0; i < len; i++) begin
      tx_valid = 1'b1;
      tx_data  = d[i];
      tx_last  = (i == len - 1);
      tx_err   = (i == err_at);
      w = 0;
      @(negedge ETH_CLK);
      if (i > MAX_FRAME) chk("discard_ready", tx_ready, 1);
      while (!tx_ready && w < 4000) begin
        @(negedge ETH_CLK);
        w++;
      end
      if (!tx_ready) begin
        chk("tx_stall", tx_ready, 1);
        break;
      end
      if (i == len - 1) t_last = cyc;
      @(posedge ETH_CLK); #1;
    end
    tx_valid = 1'b0; tx_last = 1'b0; tx_err = 1'b0;
  endtask

  task automatic drain(input string tag);
    int w = 0;
    while ((exp_q.size() != 0 || exp_drop.size() != 0) && w < 20000) begin
      @(posedge ETH_CLK); #1;
      w++;
    end
    chk(tag, exp_q.size() + exp_drop.size(), 0);
    repeat (3) begin @(posedge ETH_CLK); #1; end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_rx"}, stat_rx_frames, n_rx);
    chk({tag, "_drop"}, stat_drop_frames, n_drop);
    chk({tag, "_pend"}, frames_pending, 0);
  endtask

  initial begin
    int base, cycles;
    bit done;
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, cycles;
    bit done;
    repeat (3) @(posedge ETH_CLK);
    #1;
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", {rx_last, rx_data}, 0);
    chk("rst_pend", frames_pending, 0);
    chk("rst_stats", {stat_rx_frames, stat_drop_frames}, 0);
    chk("rst_drop", {drop_pulse, drop_cause}, 0);
    @(negedge ETH_CLK); ETH_RST = 1'b0;
    repeat (2) begin @(posedge ETH_CLK); #1; end

    // 1: single 64-byte counting frame, latency from tx_last accept
    rise_cyc = -1;
    send(64, -1, 1'b1);
    drain("t1_drain");
    chk("t1_latency", rise_cyc, t_last + 3);
    chk_stats("t1");

    // 2: three frames queued behind a stalled sink, then drained back to back
    rx_ready = 1'b0;
    send(64, -1, 1'b0);
    send(100, -1, 1'b0);
    send(1518, -1, 1'b0);
    repeat (3) begin @(posedge ETH_CLK); #1; end
    chk("t2_pend3", frames_pending, 3);
    base = rx_cnt; cycles = 0;
    rx_ready = 1'b1;
    while (rx_cnt - base < 1682 && cycles < 5000) begin
      @(posedge ETH_CLK); #1;
      cycles++;
    end
    chk("t2_no_gap", cycles, 1682);
    drain("t2_drain");
    chk_stats("t2");

    // 3: oversize frames dropped, legal frame between them passes
    send(1519, -1, 1'b0);
    send(64, -1, 1'b0);
    send(1525, -1, 1'b0);
    drain("t3_drain");
    chk_stats("t3");

    // 4: runt
    send(10, -1, 1'b0);
    drain("t4_drain");
    chk_stats("t4");

    // 5: errored frame, then frames crossing the FIFO wrap under random backpressure
    done = 1'b0;
    fork
      begin
        send(80, 5, 1'b0);
        send(150, -1, 1'b0);
        send(200, -1, 1'b0);
        drain("t5_drain");
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge ETH_CLK); #1;
          rx_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rx_ready = 1'b1;
    repeat (2) begin @(posedge ETH_CLK); #1; end
    chk_stats("t5");

    // 6: reset in the middle of an RX stream with two frames queued
    rx_ready = 1'b0;
    send(64, -1, 1'b0);
    send(64, -1, 1'b0);
    repeat (3) begin @(posedge ETH_CLK); #1; end
    rx_ready = 1'b1;
    repeat (10) @(posedge ETH_CLK);
    #2;
    ETH_RST = 1'b1;
    #1;
    chk("t6_rx_valid", rx_valid, 0);
    chk("t6_tx_ready", tx_ready, 0);
    chk("t6_pend", frames_pending, 0);
    chk("t6_stats", {stat_rx_frames, stat_drop_frames}, 0);
    exp_q.delete(); exp_drop.delete();
    n_rx = 0; n_drop = 0;
    repeat (2) @(negedge ETH_CLK);
    ETH_RST = 1'b0;
    repeat (2) begin @(posedge ETH_CLK); #1; end
    send(64, -1, 1'b0);
    drain("t6_drain");
    chk_stats("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
